// File: rtl/activity_pkg.sv
// Shared definitions for the activity counter bank: FSM encoding,
// default sizing and the readout slot of the enabled-cycle counter.
package activity_pkg;

   localparam int DEF_NUM_EVENTS = 16;
   localparam int DEF_CNT_WIDTH  = 32;
   localparam int DEF_IDX_WIDTH  = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DUMP    = 2'd2
   } state_t;

   // The cycle counter sits directly after the last event channel.
   function automatic int cycle_idx(input int num_events);
      return num_events;
   endfunction

endpackage

// File: rtl/activity_sat_counter.sv
// One counting channel: level or rising-edge qualification, saturating
// count with a sticky overflow flag, synchronous clear.
module activity_sat_counter
   import activity_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 evt,
   input  logic                 edge_sel,
   input  logic                 cntr_on,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 ovf
);

   logic prev;
   logic hit;

   // prev tracks the raw event even while counting is off, so enabling
   // with the event already high is not seen as an edge.
   assign hit = cntr_on & (edge_sel ? (evt & ~prev) : evt);

   // Saturating count; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= 1'b0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         prev <= evt;
         if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
         end else if (hit) begin
            if (&count) begin
               ovf <= 1'b1;
            end else begin
               count <= count + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/activity_counter_bank.sv
// Bank of per-event activity counters plus an enabled-cycle counter.
// A snapshot request copies all counts into a shadow bank which is then
// streamed out one channel per valid/ready transfer.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for snap_req
//   CAPTURE | copy live counts/ovf into shadow, present word 0 next
//   DUMP    | stream shadow[dump_idx], last word is the cycle counter
module activity_counter_bank
   import activity_pkg::*;
#(
   parameter int NUM_EVENTS = DEF_NUM_EVENTS,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
   input  logic                  pj_clk,
   input  logic                  pj_reset_l,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic [NUM_EVENTS-1:0] edge_mode,
   input  logic                  cntr_on,
   input  logic                  clr,
   input  logic                  snap_req,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [IDX_WIDTH-1:0]  dump_idx,
   output logic [CNT_WIDTH-1:0]  dump_data,
   output logic                  dump_ovf,
   output logic                  busy
);

   localparam int LAST = cycle_idx(NUM_EVENTS);
   localparam int NCH  = NUM_EVENTS + 1;

   logic [CNT_WIDTH-1:0] live_cnt   [NCH];
   logic [NCH-1:0]       live_ovf;
   logic [CNT_WIDTH-1:0] shadow_cnt [NCH];
   logic [NCH-1:0]       shadow_ovf;
   state_t               state;

   for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_chan
      activity_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk      (pj_clk),
         .rst_n    (pj_reset_l),
         .evt      (event_in[g]),
         .edge_sel (edge_mode[g]),
         .cntr_on  (cntr_on),
         .clr      (clr),
         .count    (live_cnt[g]),
         .ovf      (live_ovf[g])
      );
   end

   // Enabled-cycle counter: a level channel whose event is always present.
   activity_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk      (pj_clk),
      .rst_n    (pj_reset_l),
      .evt      (1'b1),
      .edge_sel (1'b0),
      .cntr_on  (cntr_on),
      .clr      (clr),
      .count    (live_cnt[LAST]),
      .ovf      (live_ovf[LAST])
   );

   // Snapshot/dump sequencer. The live registers seen in CAPTURE already
   // hold the snap_req cycle's increments (or its clear).
   always_ff @(posedge pj_clk or negedge pj_reset_l) begin
      if (!pj_reset_l) begin
         state      <= IDLE;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         shadow_ovf <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow_cnt[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               for (int i = 0; i < NCH; i++) begin
                  shadow_cnt[i] <= live_cnt[i];
               end
               shadow_ovf <= live_ovf;
               dump_idx   <= '0;
               dump_valid <= 1'b1;
               state      <= DUMP;
            end
            DUMP: begin
               if (dump_valid && dump_ready) begin
                  if (dump_idx == IDX_WIDTH'(LAST)) begin
                     dump_valid <= 1'b0;
                     dump_idx   <= '0;
                     state      <= IDLE;
                  end else begin
                     dump_idx <= dump_idx + IDX_WIDTH'(1);
                  end
               end
            end
            default: begin
               state      <= IDLE;
               dump_valid <= 1'b0;
            end
         endcase
      end
   end

   // Readout mux; outputs stay zero whenever no word is being offered.
   always_comb begin
      dump_data = '0;
      dump_ovf  = 1'b0;
      if (dump_valid) begin
         for (int i = 0; i < NCH; i++) begin
            if (dump_idx == IDX_WIDTH'(i)) begin
               dump_data = shadow_cnt[i];
               dump_ovf  = shadow_ovf[i];
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
